uart_tx_queue: RTL and testbench

Byte queue and sequencer that sits directly upstream of the UART byte transmitter. Producers push bytes at system-clock rate. The block buffers them in a synchronous FIFO and presents them one at a time on `data_byte`/`transmit_en`. It waits for the transmitter's completion rising edge on `irq` before releasing the next byte. It turns a bursty byte source into the rising-edge-per-byte handshake the transmitter expects.

---
 rtl/uart_tx_queue_if.sv | 27 ++
 rtl/uart_tx_queue.sv | 141 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter-side signal bundle for uart_tx_queue.
// master drives bytes and irq; slave is the queue itself.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH_LOG2 = 4
) ();
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic [7:0]          data_byte;
    logic                transmit_en;
    logic                irq;
    logic                busy;
    logic                timeout_err;

    modport master (
        output wr_data, wr_en, irq,
        input  full, empty, level, overflow, data_byte, transmit_en, busy, timeout_err
    );

    modport slave (
        input  wr_data, wr_en, irq,
        output full, empty, level, overflow, data_byte, transmit_en, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus sequencer producing one transmit_en rising edge per byte for a UART transmitter.
// Optional WAIT-state watchdog is built when UART_TX_QUEUE_TIMEOUT_EN is defined.
module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4096
) (
    input logic            clk_100M,
    input logic            rst,
    uart_tx_queue_if.slave bus
);
    localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StSetup, StWait, StGap} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [Depth];
    logic [7:0]      data_byte_q, data_byte_d;
    logic            transmit_en_q, transmit_en_d;
    logic            gap_q, gap_d;
    logic            overflow_q;
    logic            irq_q;
    logic            full, empty, push, pop;
    logic            irq_rise;
    logic            wdog_expire;

    // Pointers differ only in the MSB exactly when the FIFO is full.
    assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}};
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign push     = bus.wr_en & ~full;
    assign irq_rise = bus.irq & ~irq_q;

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            overflow_q <= bus.wr_en & full;
            irq_q      <= bus.irq;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.wr_data;
    end

    always_comb begin
        state_d       = state_q;
        data_byte_d   = data_byte_q;
        transmit_en_d = transmit_en_q;
        gap_d         = gap_q;
        pop           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    data_byte_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                transmit_en_d = 1'b1;
                state_d       = StWait;
            end
            StWait: begin
                // A watchdog expiry leaves through GAP like a completion; the byte is not retried.
                if (irq_rise || wdog_expire) begin
                    transmit_en_d = 1'b0;
                    gap_d         = 1'b0;
                    state_d       = StGap;
                end
            end
            StGap: begin
                if (gap_q) state_d = StIdle;
                gap_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            data_byte_q   <= 8'h00;
            transmit_en_q <= 1'b0;
            gap_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_byte_q   <= data_byte_d;
            transmit_en_q <= transmit_en_d;
            gap_q         <= gap_d;
        end
    end

`ifdef UART_TX_QUEUE_TIMEOUT_EN
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_err_q;

    assign wdog_expire = (state_q == StWait) && !irq_rise && ((wdog_q + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StSetup) begin
            wdog_d = '0;
        end else if (state_q == StWait) begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_q | wdog_expire;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wdog_expire        = 1'b0;
    assign bus.timeout_err    = 1'b0;
`endif

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.level       = wr_ptr_q - rd_ptr_q;
    assign bus.overflow    = overflow_q;
    assign bus.data_byte   = data_byte_q;
    assign bus.transmit_en = transmit_en_q;
    assign bus.busy        = state_q != StIdle;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios with random bytes and random irq delays
// checked against a byte-order queue and the block's cycle-level latency rules.
module tb_uart_tx_queue;
`ifdef UART_TX_QUEUE_TIMEOUT_EN
    localparam int SingleDelay = 50;
`else
    localparam int SingleDelay = 1085;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic [7:0] model_q[$];

    uart_tx_queue_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_queue #(
        .DEPTH_LOG2    (4),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk_100M(clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Services n queued bytes like a transmitter: checks order and the 5-cycle restart rule.
    task automatic drain(input int n);
        int         last_irq;
        bit         have_prev;
        int         waited;
        logic [7:0] exp_b;
        have_prev = 1'b0;
        last_irq  = 0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (bus.transmit_en !== 1'b1 && waited < 200) begin
                step();
                waited++;
            end
            n_cmp++;
            if (waited >= 200) begin
                n_fail++;
                $display("FAIL drain_start: transmit_en got 0 expected 1 within 200 cycles (byte %0d)", i);
                return;
            end
            exp_b = model_q.pop_front();
            n_cmp++;
            if (bus.data_byte !== exp_b) begin
                n_fail++;
                $display("FAIL drain_data: byte %0d got %02h expected %02h", i, bus.data_byte, exp_b);
            end
            if (have_prev) begin
                n_cmp++;
                if (cyc - last_irq != 5) begin
                    n_fail++;
                    $display("FAIL drain_spacing: got %0d cycles expected 5", cyc - last_irq);
                end
            end
            repeat ($urandom_range(0, 30)) step();
            bus.irq   = 1'b1;
            last_irq  = cyc;
            have_prev = 1'b1;
            step();
            n_cmp++;
            if (bus.transmit_en !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_fall: transmit_en got %0b expected 0", bus.transmit_en);
            end
            repeat ($urandom_range(0, 2)) step();
            bus.irq = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] b;
        int         waited;
        int         bad;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.irq = 1'b0;
        repeat (3) step();
        n_cmp += 8;
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL reset_te: got %0b expected 0", bus.transmit_en); end
        if (bus.data_byte !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", bus.data_byte); end
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", bus.full); end
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", bus.empty); end
        if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", bus.overflow); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %0b expected 0", bus.timeout_err); end
        rst = 1'b0;
        step();
        // Four writes into an empty queue: one is taken by the sequencer, three remain.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            bus.wr_en = 1'b1;
            bus.wr_data = b;
            step();
        end
        bus.wr_en = 1'b0;
        waited = 0;
        while (bus.transmit_en !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp += 2;
        if (bus.transmit_en !== 1'b1) begin n_fail++; $display("FAIL midreset_wait: te got %0b expected 1", bus.transmit_en); end
        if (bus.level !== 5'd3) begin n_fail++; $display("FAIL midreset_level: got %0d expected 3", bus.level); end
        #2 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL midreset_te: got %0b expected 0", bus.transmit_en); end
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL midreset_empty: got %0b expected 1", bus.empty); end
        if (bus.level !== 5'd0) begin n_fail++; $display("FAIL midreset_lvl0: got %0d expected 0", bus.level); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b expected 0", bus.busy); end
        if (bus.data_byte !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %02h expected 00", bus.data_byte); end
        step();
        rst = 1'b0;
        step();
        bus.irq = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (bus.transmit_en !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL postreset_irq: active cycles got %0d expected 0", bad); end
        bus.irq = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        int bad;
        repeat (6) step();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        n_cmp++;
        if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_c1_empty: got %0b expected 0", bus.empty); end
        step();
        n_cmp += 3;
        if (bus.data_byte !== 8'hA5) begin n_fail++; $display("FAIL single_c2_data: got %02h expected a5", bus.data_byte); end
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL single_c2_te: got %0b expected 0", bus.transmit_en); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_c2_busy: got %0b expected 1", bus.busy); end
        step();
        n_cmp++;
        if (bus.transmit_en !== 1'b1) begin n_fail++; $display("FAIL single_c3_te: got %0b expected 1", bus.transmit_en); end
        bad = 0;
        repeat (SingleDelay) begin
            step();
            if (bus.transmit_en !== 1'b1) bad++;
        end
        n_cmp += 2;
        if (bad != 0) begin n_fail++; $display("FAIL single_hold: low cycles got %0d expected 0", bad); end
        if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL single_tmo: got %0b expected 0", bus.timeout_err); end
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        n_cmp += 2;
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL single_fall: got %0b expected 0", bus.transmit_en); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_gap1_busy: got %0b expected 1", bus.busy); end
        step();
        n_cmp += 2;
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL single_gap2_te: got %0b expected 0", bus.transmit_en); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_gap2_busy: got %0b expected 1", bus.busy); end
        step();
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_burst();
        repeat (6) step();
        model_q.delete();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            model_q.push_back(8'(i));
            step();
        end
        n_cmp += 2;
        if (bus.level !== 5'd15) begin n_fail++; $display("FAIL burst_lvl15: got %0d expected 15", bus.level); end
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL burst_notfull: got %0b expected 0", bus.full); end
        bus.wr_data = 8'h10;
        model_q.push_back(8'h10);
        step();
        n_cmp += 3;
        if (bus.level !== 5'd16) begin n_fail++; $display("FAIL burst_lvl16: got %0d expected 16", bus.level); end
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL burst_full: got %0b expected 1", bus.full); end
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL burst_noovf: got %0b expected 0", bus.overflow); end
        bus.wr_data = 8'h11;
        step();
        bus.wr_en = 1'b0;
        n_cmp += 2;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf: got %0b expected 1", bus.overflow); end
        if (bus.level !== 5'd16) begin n_fail++; $display("FAIL burst_ovf_lvl: got %0d expected 16", bus.level); end
        step();
        n_cmp++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf_pulse: got %0b expected 0", bus.overflow); end
        drain(17);
    endtask

    task automatic test_simultaneous();
        logic [7:0] b;
        repeat (6) step();
        model_q.delete();
        b = 8'($urandom);
        bus.wr_en = 1'b1;
        bus.wr_data = b;
        model_q.push_back(b);
        step();
        n_cmp++;
        if (bus.level !== 5'd1) begin n_fail++; $display("FAIL simul_lvl_before: got %0d expected 1", bus.level); end
        b = 8'($urandom);
        bus.wr_data = b;
        model_q.push_back(b);
        step();
        n_cmp++;
        if (bus.level !== 5'd1) begin n_fail++; $display("FAIL simul_lvl_same: got %0d expected 1", bus.level); end
        for (int i = 0; i < 15; i++) begin
            b = 8'($urandom);
            bus.wr_data = b;
            model_q.push_back(b);
            step();
        end
        bus.wr_en = 1'b0;
        n_cmp += 2;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %0b expected 1", bus.full); end
        if (bus.data_byte !== model_q[0]) begin
            n_fail++;
            $display("FAIL simul_head: got %02h expected %02h", bus.data_byte, model_q[0]);
        end
        void'(model_q.pop_front());
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        step();
        step();
        // IDLE pops this cycle while full: the write must still be dropped.
        n_cmp += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: busy got %0b expected 0", bus.busy); end
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL simul_full2: got %0b expected 1", bus.full); end
        bus.wr_en = 1'b1;
        bus.wr_data = 8'($urandom);
        step();
        bus.wr_en = 1'b0;
        n_cmp += 2;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL simul_ovf: got %0b expected 1", bus.overflow); end
        if (bus.level !== 5'd15) begin n_fail++; $display("FAIL simul_lvl15: got %0d expected 15", bus.level); end
        drain(16);
    endtask

    task automatic test_stale_irq();
        logic [7:0] b;
        int         waited;
        int         bad;
        repeat (6) step();
        model_q.delete();
        b = 8'($urandom);
        bus.irq = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en = 1'b0;
        waited = 0;
        while (bus.transmit_en !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp += 2;
        if (bus.transmit_en !== 1'b1) begin n_fail++; $display("FAIL stale_start: te got %0b expected 1", bus.transmit_en); end
        if (bus.data_byte !== b) begin n_fail++; $display("FAIL stale_data: got %02h expected %02h", bus.data_byte, b); end
        bad = 0;
        repeat (20) begin
            step();
            if (bus.transmit_en !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL stale_hold: released cycles got %0d expected 0", bad); end
        bus.irq = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        n_cmp++;
        if (bus.transmit_en !== 1'b0) begin n_fail++; $display("FAIL stale_fall: got %0b expected 0", bus.transmit_en); end
    endtask

`ifdef UART_TX_QUEUE_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b0, b1;
        int         t_rise, t_fall, waited;
        repeat (6) step();
        model_q.delete();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        bus.wr_en = 1'b1;
        bus.wr_data = b0;
        step();
        bus.wr_data = b1;
        step();
        bus.wr_en = 1'b0;
        waited = 0;
        while (bus.transmit_en !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        t_rise = cyc;
        n_cmp++;
        if (bus.data_byte !== b0) begin n_fail++; $display("FAIL tmo_data0: got %02h expected %02h", bus.data_byte, b0); end
        waited = 0;
        while (bus.transmit_en !== 1'b0 && waited < 300) begin
            step();
            waited++;
        end
        t_fall = cyc;
        n_cmp += 2;
        if (t_fall - t_rise != 100) begin n_fail++; $display("FAIL tmo_len: got %0d expected 100", t_fall - t_rise); end
        if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %0b expected 1", bus.timeout_err); end
        waited = 0;
        while (bus.transmit_en !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp += 2;
        if (cyc - t_fall != 4) begin n_fail++; $display("FAIL tmo_restart: got %0d expected 4", cyc - t_fall); end
        if (bus.data_byte !== b1) begin n_fail++; $display("FAIL tmo_data1: got %02h expected %02h", bus.data_byte, b1); end
        model_q.push_back(b1);
        drain(1);
        repeat (6) step();
        n_cmp++;
        if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0b expected 1", bus.timeout_err); end
    endtask
`endif

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.irq = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_simultaneous();
        test_stale_irq();
`ifdef UART_TX_QUEUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation got 50000 cycles expected completion earlier");
        $fatal(1, "bench watchdog expired");
    end
endmodule
